xy_out_arbiter: RTL
===================

XY_OUT_ARBITER -- requirements
Module: xy_out_arbiter

Interface
REQ-001 The block SHALL have parameter PORT_N, default 5, giving the number of requesting input ports (one per switch input FIFO).
REQ-002 The block SHALL have parameter PCKT_W, default 16, giving the packet width in bits (X addr + Y addr + data).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_i, input, PORT_N bits: bit k set = input FIFO k non-empty and its head packet routed to this output.
REQ-006 The block SHALL have port pckt_i, input, PCKT_W*PORT_N bits: head packet of each input FIFO (first-word-fall-through); port k occupies bits [PCKT_W*k +: PCKT_W].
REQ-007 The block SHALL have port rd_en_o, output, PORT_N bits: one-hot pop strobe to the granted input FIFO.
REQ-008 The block SHALL have port nxt_fifo_full_i, input, 1 bit: next-hop FIFO full.
REQ-009 The block SHALL have port wr_en_o, output, 1 bit: write strobe to the next-hop FIFO.
REQ-010 The block SHALL have port pckt_o, output, PCKT_W bits: packet presented to the next-hop FIFO.
REQ-011 The block SHALL have port grant_o, output, PORT_N bits: registered one-hot index of the port whose packet sits in pckt_o; all-zero when empty.
REQ-012 The block SHALL have port stall_o, output, 1 bit: high while a held packet is blocked by nxt_fifo_full_i.

Function
REQ-013 The block SHALL contain a one-entry output register (valid flag, packet, source index) and a FSM with states IDLE (register empty), XFER (register valid, next FIFO not full), STALL (register valid, next FIFO full).
REQ-014 wr_en_o SHALL equal valid AND NOT nxt_fifo_full_i, combinationally; pckt_o SHALL be the register contents.
REQ-015 The register SHALL accept a new packet in a cycle when NOT valid OR wr_en_o (full-throughput refill on drain).
REQ-016 In an accepting cycle with req_i non-zero, arbitration SHALL pick the first set bit of req_i searching upward from rr_ptr with wrap from PORT_N-1 to 0; rd_en_o SHALL pulse for that bit in the same cycle; the chosen pckt_i slice, valid=1 and grant_o index SHALL be loaded at the next edge.
REQ-017 rd_en_o SHALL be all-zero in any non-accepting cycle or when req_i is zero; at most one bit SHALL ever be set.
REQ-018 rr_ptr (width clog2(PORT_N)) SHALL update only on a grant, to (granted index + 1) mod PORT_N; it SHALL hold otherwise.
REQ-019 Latency req_i rise -> wr_en_o SHALL be 1 cycle when idle and next FIFO not full; sustained throughput SHALL be one packet per cycle.
REQ-020 When wr_en_o fires and no new grant occurs, valid SHALL clear and grant_o SHALL go all-zero at the next edge (XFER->IDLE).
REQ-021 FSM transitions: IDLE->XFER/STALL on grant (by nxt_fifo_full_i next cycle); XFER->STALL when nxt_fifo_full_i rises; STALL->XFER when it falls; stall_o = (state==STALL).
REQ-022 In STALL the packet, grant_o and rr_ptr SHALL hold unchanged and no rd_en_o SHALL issue.
REQ-023 A req_i bit dropping while not granted SHALL have no effect; a req_i bit for an already-popped packet is the source FIFO's responsibility.

Reset
REQ-024 While rst_i is high at a clock edge: valid=0, state=IDLE, rr_ptr=0, pckt_o=0, grant_o=0; rd_en_o and wr_en_o SHALL be 0 during reset cycles irrespective of req_i.
REQ-025 Reset asserted mid-transfer or in STALL SHALL discard the held packet without issuing wr_en_o.

Verification
REQ-026 Reset then req_i=5'b00100, pckt_i slice2=16'hA5C3, full=0 -> rd_en_o=5'b00100 same cycle; next cycle wr_en_o=1, pckt_o=16'hA5C3, grant_o=5'b00100; rr_ptr=3.
REQ-027 req_i=5'b11111 held for 10 cycles, full=0 -> grants in order 0,1,2,3,4,0,1,2,3,4; wr_en_o high every cycle from cycle 2.
REQ-028 Packet held, nxt_fifo_full_i=1 for 4 cycles -> stall_o=1, wr_en_o=0, rd_en_o=0, pckt_o stable for 4 cycles; full falls -> wr_en_o=1 same cycle and next grant pops.
REQ-029 rr_ptr=3, req_i=5'b00011 -> grant port 0, then port 1; rr_ptr wraps 3->1->2.
REQ-030 rst_i pulsed while in STALL with req_i=5'b10000 -> no wr_en_o/rd_en_o that cycle; after release grant_o=0, first grant is port 4 and rr_ptr becomes 0.

Source files
------------

// File: rtl/xy_out_arbiter.sv
// XY-router output-port arbiter: round-robin selection among input FIFOs
// whose head packet targets this output, feeding a one-entry output
// register that drains into the next-hop FIFO. The register refills in the
// same cycle it drains, so sustained throughput is one packet per clock.
module xy_out_arbiter #(
    parameter int PORT_N = 5,
    parameter int PCKT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PORT_N-1:0]        req_i,
    input  logic [PCKT_W*PORT_N-1:0] pckt_i,
    output logic [PORT_N-1:0]        rd_en_o,
    input  logic                     nxt_fifo_full_i,
    output logic                     wr_en_o,
    output logic [PCKT_W-1:0]        pckt_o,
    output logic [PORT_N-1:0]        grant_o,
    output logic                     stall_o
);

    localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    // Occupancy states of the output register.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    logic              valid_reg;
    logic [PCKT_W-1:0] pckt_reg;
    logic [PORT_N-1:0] grant_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [PTR_W-1:0]  rr_ptr_next;

    logic [1:0]        state;
    logic              wr_en;
    logic              accept;
    logic              found;
    logic              grant_any;
    logic [PTR_W-1:0]  pick_idx;
    logic [PORT_N-1:0] pick_onehot;
    logic [PTR_W:0]    idx_sum;
    logic [PTR_W-1:0]  cand;

    logic [PCKT_W-1:0] pckt_slice [PORT_N];

    // Unpack the flat head-packet bus into one slice per input port.
    generate
        for (genvar gi = 0; gi < PORT_N; gi++) begin : g_slice
            assign pckt_slice[gi] = pckt_i[gi*PCKT_W +: PCKT_W];
        end
    endgenerate

    // Drain strobe; suppressed while reset is asserted so a held packet is dropped.
    assign wr_en  = ~rst_i & valid_reg & ~nxt_fifo_full_i;
    // Register can take a packet when empty or when it is draining this cycle.
    assign accept = ~rst_i & (~valid_reg | wr_en);

    // Round-robin search: first requesting port at or above rr_ptr, wrapping.
    always_comb begin
        found   = 1'b0;
        pick_idx = '0;
        idx_sum = '0;
        cand    = '0;
        for (int i = 0; i < PORT_N; i++) begin
            idx_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (idx_sum >= (PTR_W+1)'(PORT_N)) begin
                idx_sum = idx_sum - (PTR_W+1)'(PORT_N);
            end
            cand = idx_sum[PTR_W-1:0];
            if (!found && req_i[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // One-hot form of the chosen port and the pointer value after granting it.
    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
        if (pick_idx == PTR_W'(PORT_N - 1)) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = pick_idx + PTR_W'(1);
        end
    end

    assign grant_any = accept & found;

    // Output register, source index and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg  <= 1'b0;
            pckt_reg   <= '0;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else if (accept) begin
            if (found) begin
                valid_reg  <= 1'b1;
                pckt_reg   <= pckt_slice[pick_idx];
                grant_reg  <= pick_onehot;
                rr_ptr_reg <= rr_ptr_next;
            end else begin
                // Drained with nothing to refill: packet bits are left as-is.
                valid_reg <= 1'b0;
                grant_reg <= '0;
            end
        end
    end

    // State decode: STALL tracks the full flag in the same cycle so that the
    // stall indication and the withheld write strobe always coincide.
    always_comb begin
        state = ST_IDLE;
        if (valid_reg) begin
            state = nxt_fifo_full_i ? ST_STALL : ST_XFER;
        end
    end

    assign rd_en_o = grant_any ? pick_onehot : '0;
    assign wr_en_o = wr_en;
    assign pckt_o  = pckt_reg;
    assign grant_o = grant_reg;
    assign stall_o = (state == ST_STALL);

endmodule
